// File: rtl/joy_nes_pad_if.sv
// ---------------------------------------------------------------------------
// joy_nes_pad_if
//
// Presents two MSX-style joystick ports plus Select/Start buttons as two NES
// standard controllers at $4016/$4017.
// The path is: 2-flop synchroniser, per-bit debounce, optional SOCD masking,
// then a strobe-latched shift register per port that the CPU reads serially.
//
// Parameters
//   DEB_W      debounce counter width; an input must hold steady for
//              2^DEB_W-1 clocks before the debounced state follows it
//   SOCD_MASK  1 = U+D or L+R pressed together both read as released
//
// Ports
//   CLK        system clock
//   RSTn       asynchronous active-low reset
//   JoyA/JoyB  raw port 0/1 inputs, active-high:
//              [0]Up [1]Down [2]Left [3]Right [4]TrgA [5]TrgB
//   SysBtnA/B  port 0/1 [0]Select [1]Start, active-high, asynchronous
//   strobe_we  one-cycle pulse, CPU write to $4016
//   strobe_d   bit 0 of that write
//   rd_en      one-cycle pulses: [0] read of $4016, [1] read of $4017
//   rd_data    serial bit per port, valid in the same cycle as rd_en
//   btn_dbg    debounced (and masked) state {portB[7:0], portA[7:0]},
//              NES order A,B,Select,Start,Up,Down,Left,Right from bit 0
// ---------------------------------------------------------------------------
module joy_nes_pad_if #(
  parameter int DEB_W     = 16,
  parameter bit SOCD_MASK = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [5:0]  JoyA,
  input  logic [5:0]  JoyB,
  input  logic [1:0]  SysBtnA,
  input  logic [1:0]  SysBtnB,
  input  logic        strobe_we,
  input  logic        strobe_d,
  input  logic [1:0]  rd_en,
  output logic [1:0]  rd_data,
  output logic [15:0] btn_dbg
);

  function automatic logic [7:0] nesOrder(input logic [5:0] joy, input logic [1:0] sys);
    return {joy[3], joy[2], joy[1], joy[0], sys[1], sys[0], joy[5], joy[4]};
  endfunction

  // Opposing directions cancel each other out.
  function automatic logic [7:0] socdMask(input logic [7:0] btn);
    logic [7:0] res;
    res = btn;
    if (btn[4] && btn[5]) begin
      res[4] = 1'b0;
      res[5] = 1'b0;
    end
    if (btn[6] && btn[7]) begin
      res[6] = 1'b0;
      res[7] = 1'b0;
    end
    return res;
  endfunction

  // The read counter stops at 8; from then on the port reads back 1.
  function automatic logic [3:0] satInc(input logic [3:0] cnt);
    return (cnt == 4'd8) ? cnt : cnt + 4'd1;
  endfunction

  logic [15:0]      rawBtn;
  logic [15:0]      btnSync_p0;
  logic [15:0]      btnSync_p1;
  logic [DEB_W-1:0] debCnt [16];
  logic [15:0]      debState;
  logic [15:0]      btnMasked;
  logic             strobe;
  logic [1:0][7:0]  shreg;
  logic [1:0][3:0]  readCnt;

  assign rawBtn = {nesOrder(JoyB, SysBtnB), nesOrder(JoyA, SysBtnA)};

  // ---- stage p0/p1: two-flop synchroniser ----
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      btnSync_p0 <= '0;
      btnSync_p1 <= '0;
    end else begin
      btnSync_p0 <= rawBtn;
      btnSync_p1 <= btnSync_p0;
    end
  end

  // ---- debounce: count stable clocks of a pending change ----
  // The counter only runs while the synced bit disagrees with the debounced
  // bit; any bounce back to the debounced value clears it, so the change is
  // accepted only after 2^DEB_W-1 uninterrupted clocks. It never wraps.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 16; i++) debCnt[i] <= '0;
      debState <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (btnSync_p1[i] == debState[i]) begin
          debCnt[i] <= '0;
        end else if (&debCnt[i]) begin
          debState[i] <= btnSync_p1[i];
          debCnt[i]   <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + 1'b1;
        end
      end
    end
  end

  assign btnMasked = SOCD_MASK ? {socdMask(debState[15:8]), socdMask(debState[7:0])}
                               : debState;
  assign btn_dbg   = btnMasked;

  // ---- latch / shift: strobe register and per-port shift registers ----
  // A strobe write (or a strobe already high) reloads and wins over any read
  // in the same cycle; the last strobe=1 cycle leaves the snapshot in place.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      strobe  <= 1'b0;
      shreg   <= '0;
      readCnt <= {4'd8, 4'd8};
    end else begin
      if (strobe_we) strobe <= strobe_d;
      for (int n = 0; n < 2; n++) begin
        if (strobe || (strobe_we && strobe_d)) begin
          shreg[n]   <= btnMasked[8*n +: 8];
          readCnt[n] <= 4'd0;
        end else if (rd_en[n] && !strobe_we) begin
          shreg[n]   <= {1'b1, shreg[n][7:1]};
          readCnt[n] <= satInc(readCnt[n]);
        end
      end
    end
  end

  // Zero-latency read path: with strobe high the live A button is returned.
  always_comb begin
    rd_data = 2'b11;
    for (int n = 0; n < 2; n++) begin
      if (strobe)               rd_data[n] = btnMasked[8*n];
      else if (!readCnt[n][3])  rd_data[n] = shreg[n][0];
    end
  end

endmodule

// File: tb/tb_joy_nes_pad_if.sv
module tb_joy_nes_pad_if;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [5:0]  JoyA, JoyB;
  logic [1:0]  SysBtnA, SysBtnB;
  logic        strobe_we, strobe_d;
  logic [1:0]  rd_en;
  logic [1:0]  rd_data, rd_data0;
  logic [15:0] btn_dbg, btn_dbg0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  joy_nes_pad_if #(.DEB_W(8), .SOCD_MASK(1'b1)) dut (
    .CLK(CLK), .RSTn(RSTn), .JoyA(JoyA), .JoyB(JoyB),
    .SysBtnA(SysBtnA), .SysBtnB(SysBtnB),
    .strobe_we(strobe_we), .strobe_d(strobe_d), .rd_en(rd_en),
    .rd_data(rd_data), .btn_dbg(btn_dbg)
  );

  // Same inputs, no SOCD masking.
  joy_nes_pad_if #(.DEB_W(8), .SOCD_MASK(1'b0)) dutNoMask (
    .CLK(CLK), .RSTn(RSTn), .JoyA(JoyA), .JoyB(JoyB),
    .SysBtnA(SysBtnA), .SysBtnB(SysBtnB),
    .strobe_we(strobe_we), .strobe_d(strobe_d), .rd_en(rd_en),
    .rd_data(rd_data0), .btn_dbg(btn_dbg0)
  );

  typedef struct {
    logic [5:0]  joyA;
    logic [5:0]  joyB;
    logic [1:0]  sysA;
    logic [1:0]  sysB;
    logic [15:0] expDbg;
    logic [15:0] expDbgNoMask;
    logic [8:0]  expRd0;   // bit i = value returned by read i+1
    logic [8:0]  expRd1;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic setBtns(input logic [5:0] ja, input logic [5:0] jb,
                         input logic [1:0] sa, input logic [1:0] sb);
    @(negedge CLK);
    JoyA = ja; JoyB = jb; SysBtnA = sa; SysBtnB = sb;
  endtask

  // Strobe 1 then 0: the snapshot is taken in the strobe=1 cycle.
  task automatic latch();
    @(negedge CLK);
    strobe_we = 1'b1; strobe_d = 1'b1;
    @(negedge CLK);
    strobe_d = 1'b0;
    @(negedge CLK);
    strobe_we = 1'b0;
  endtask

  task automatic readOne(input logic [1:0] en, output logic [1:0] d);
    @(negedge CLK);
    rd_en = en;
    #1;
    d = rd_data;
    @(posedge CLK);
    #1;
    rd_en = 2'b00;
  endtask

  task automatic readSeq(input int n, input logic [1:0] en,
                         output logic [8:0] r0, output logic [8:0] r1);
    logic [1:0] d;
    r0 = '0; r1 = '0;
    for (int i = 0; i < n; i++) begin
      readOne(en, d);
      r0[i] = d[0];
      r1[i] = d[1];
    end
  endtask

  initial begin
    logic [8:0] r0, r1;
    logic [1:0] d;

    //             joyA       joyB       sysA   sysB   dbg       dbgNoMask  rd0     rd1
    vecs[0] = '{6'b010001, 6'b000000, 2'b00, 2'b00, 16'h0011, 16'h0011, 9'h111, 9'h100};
    vecs[1] = '{6'b000000, 6'b000000, 2'b01, 2'b10, 16'h0804, 16'h0804, 9'h104, 9'h108};
    vecs[2] = '{6'b000111, 6'b101100, 2'b00, 2'b00, 16'h0240, 16'hC270, 9'h140, 9'h102};
    vecs[3] = '{6'b111111, 6'b110000, 2'b11, 2'b00, 16'h030F, 16'h03FF, 9'h10F, 9'h103};
    vecs[4] = '{6'b101000, 6'b000010, 2'b00, 2'b10, 16'h2882, 16'h2882, 9'h182, 9'h128};

    RSTn = 1'b0;
    JoyA = '0; JoyB = '0; SysBtnA = '0; SysBtnB = '0;
    strobe_we = 1'b0; strobe_d = 1'b0; rd_en = 2'b00;
    waitClk(3);
    check("rst_rd_data", rd_data, 2'b11);
    check("rst_btn_dbg", btn_dbg, 16'h0000);
    check("rst_btn_dbg_nomask", btn_dbg0, 16'h0000);
    @(negedge CLK);
    RSTn = 1'b1;

    // Table-driven vectors: debounce, mapping, SOCD, 8 reads + saturation.
    for (int v = 0; v < 5; v++) begin
      setBtns(vecs[v].joyA, vecs[v].joyB, vecs[v].sysA, vecs[v].sysB);
      waitClk(300);
      check($sformatf("vec%0d_btn_dbg", v), btn_dbg, vecs[v].expDbg);
      check($sformatf("vec%0d_btn_dbg_nomask", v), btn_dbg0, vecs[v].expDbgNoMask);
      latch();
      readSeq(9, 2'b11, r0, r1);
      check($sformatf("vec%0d_rd0", v), r0, vecs[v].expRd0);
      check($sformatf("vec%0d_rd1", v), r1, vecs[v].expRd1);
    end

    // Glitch rejection on JoyB[5] (port 1 B button -> btn_dbg[9]).
    setBtns(6'b000000, 6'b000000, 2'b00, 2'b00);
    waitClk(300);
    @(negedge CLK);
    JoyB = 6'b100000;
    waitClk(100);
    JoyB = 6'b000000;
    waitClk(300);
    check("glitch_short", btn_dbg[9], 1'b0);
    JoyB = 6'b100000;
    waitClk(300);
    check("glitch_long", btn_dbg[9], 1'b1);

    // Strobe held high: reads return live A, no shifting.
    setBtns(6'b010000, 6'b000000, 2'b00, 2'b00);
    waitClk(300);
    @(negedge CLK);
    strobe_we = 1'b1; strobe_d = 1'b1;
    @(negedge CLK);
    strobe_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      readOne(2'b11, d);
      check($sformatf("strobe_hi_rd%0d", i), d, 2'b01);
    end
    setBtns(6'b010000, 6'b000000, 2'b10, 2'b00);
    waitClk(300);
    check("strobe_hi_start_dbg", btn_dbg[3], 1'b1);
    readOne(2'b01, d);
    check("strobe_hi_start_rd", d[0], 1'b1);
    setBtns(6'b010000, 6'b000000, 2'b00, 2'b00);
    waitClk(300);
    check("strobe_hi_release_dbg", btn_dbg[3], 1'b0);
    setBtns(6'b010000, 6'b000000, 2'b10, 2'b00);
    waitClk(300);
    @(negedge CLK);
    strobe_we = 1'b1; strobe_d = 1'b0;
    @(negedge CLK);
    strobe_we = 1'b0;
    // Release Start after strobe fell: the snapshot must keep Start=1.
    setBtns(6'b010000, 6'b000000, 2'b00, 2'b00);
    waitClk(300);
    check("strobe_lo_start_dbg", btn_dbg[3], 1'b0);
    readSeq(9, 2'b01, r0, r1);
    check("strobe_lo_seq", r0, 9'h109);

    // strobe_we colliding with rd_en: no shift. Port 0 = A,Select (8'h05).
    setBtns(6'b010000, 6'b000000, 2'b01, 2'b00);
    waitClk(300);
    latch();
    readOne(2'b01, d);
    check("col_first_A", d[0], 1'b1);
    @(negedge CLK);
    strobe_we = 1'b1; strobe_d = 1'b0; rd_en = 2'b01;
    #1;
    check("col_cycle_B", rd_data[0], 1'b0);
    @(posedge CLK);
    #1;
    strobe_we = 1'b0; rd_en = 2'b00;
    readSeq(2, 2'b01, r0, r1);
    check("col_no_shift", r0, 9'h002);
    @(negedge CLK);
    strobe_we = 1'b1; strobe_d = 1'b1; rd_en = 2'b01;
    @(posedge CLK);
    #1;
    strobe_we = 1'b0; rd_en = 2'b00;
    @(negedge CLK);
    strobe_we = 1'b1; strobe_d = 1'b0;
    @(negedge CLK);
    strobe_we = 1'b0;
    readSeq(3, 2'b01, r0, r1);
    check("col_reload", r0, 9'h005);

    // Async reset in the middle of a read sequence.
    setBtns(6'b101000, 6'b000010, 2'b00, 2'b10);
    waitClk(300);
    latch();
    readSeq(2, 2'b11, r0, r1);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("midrst_rd_data", rd_data, 2'b11);
    check("midrst_btn_dbg", btn_dbg, 16'h0000);
    waitClk(2);
    @(negedge CLK);
    RSTn = 1'b1;
    waitClk(20);
    check("postrst_debounce_restart", btn_dbg, 16'h0000);
    waitClk(300);
    check("postrst_btn_dbg", btn_dbg, 16'h2882);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
